sram_port_arbiter: RTL and testbench

- Shares the single RW port (port 0) of the 32x256 SRAM macro between two requesters: requester 0 is the Wishbone SRAM wrapper, requester 1 is a streaming client such as a UART RX-to-SRAM logger.
- Performs round-robin arbitration with a bounded burst length, so a busy requester cannot hold the port indefinitely.
- Drives the SRAM command pins and tracks in-flight reads, returning each read's data to the requester that issued it.
- Sits between the requesters and the SRAM macro; all logic runs in the wb_clk_i domain.

---
 rtl/sram_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares the single RW port of the 32x256 SRAM macro between
// two requesters. Requester 0 is the Wishbone SRAM wrapper, and requester 1 is a
// streaming client.
//
// Arbitration is round-robin with a bounded burst. While both requesters are
// asking, the current owner keeps the port for at most MAX_BURST consecutive
// grants.
//
// Reads have a fixed latency of two cycles from the grant cycle. Each read's
// data is returned to the requester that issued it.
//
// Ports:
//   wb_clk_i, rst_n                : clock and async active-low reset
//   mN_req/we/addr/wdata/wmask     : requester N command (held until mN_gnt)
//   mN_gnt                         : command accepted this cycle (combinational)
//   mN_rvalid, mN_rdata            : read-return pulse and held read data
//   sram_csb/web/wmask/addr/din    : macro command pins (combinational)
//   sram_dout                      : macro read data, valid the cycle after capture
module sram_port_arbiter #(
    parameter int unsigned ADDR_WD   = 8,
    parameter int unsigned DATA_WD   = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 rst_n,

    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [ADDR_WD-1:0]   m0_addr,
    input  logic [DATA_WD-1:0]   m0_wdata,
    input  logic [DATA_WD/8-1:0] m0_wmask,
    output logic                 m0_gnt,
    output logic                 m0_rvalid,
    output logic [DATA_WD-1:0]   m0_rdata,

    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDR_WD-1:0]   m1_addr,
    input  logic [DATA_WD-1:0]   m1_wdata,
    input  logic [DATA_WD/8-1:0] m1_wmask,
    output logic                 m1_gnt,
    output logic                 m1_rvalid,
    output logic [DATA_WD-1:0]   m1_rdata,

    output logic                 sram_csb,
    output logic                 sram_web,
    output logic [DATA_WD/8-1:0] sram_wmask,
    output logic [ADDR_WD-1:0]   sram_addr,
    output logic [DATA_WD-1:0]   sram_din,
    input  logic [DATA_WD-1:0]   sram_dout
);

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    logic                 owner_q, owner_d;
    logic [3:0]           burst_q, burst_d;
    logic                 s1_vld_q, s1_id_q;
    logic                 s2_vld_q, s2_id_q;
    logic [DATA_WD-1:0]   rdata0_q, rdata1_q;

    logic                 keep_owner;
    logic                 gnt_vld;
    logic                 gnt_id;
    logic                 sel_we;
    logic [ADDR_WD-1:0]   sel_addr;
    logic [DATA_WD-1:0]   sel_wdata;
    logic [DATA_WD/8-1:0] sel_wmask;

    // A zero burst count means no streak has started yet (only after reset). In
    // that case the pointer passes to the non-owner, so requester 0 wins first.
    assign keep_owner = (burst_q != 4'd0) && (burst_q < MaxBurst);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (rst_n) begin
            if (m0_req && m1_req) begin
                gnt_vld = 1'b1;
                gnt_id  = keep_owner ? owner_q : ~owner_q;
            end else if (m0_req) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (m1_req) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign m0_gnt = gnt_vld & ~gnt_id;
    assign m1_gnt = gnt_vld & gnt_id;

    always_comb begin
        sel_we    = m0_we;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        sel_wmask = m0_wmask;
        if (gnt_id) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_wmask = m1_wmask;
        end
    end

    // Command pins are forced to their idle values whenever nothing is granted.
    assign sram_csb   = ~gnt_vld;
    assign sram_web   = ~(gnt_vld & sel_we);
    assign sram_wmask = (gnt_vld && sel_we) ? sel_wmask : '0;
    assign sram_addr  = gnt_vld ? sel_addr : '0;
    assign sram_din   = gnt_vld ? sel_wdata : '0;

    always_comb begin
        owner_d = owner_q;
        burst_d = burst_q;
        if (gnt_vld) begin
            if (gnt_id == owner_q) begin
                burst_d = (burst_q == 4'hF) ? 4'hF : burst_q + 4'd1;
            end else begin
                owner_d = gnt_id;
                burst_d = 4'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= 1'b1;
            burst_q  <= 4'd0;
            s1_vld_q <= 1'b0;
            s1_id_q  <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_id_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            // Stage 1 tags the read captured by the macro this cycle.
            s1_vld_q <= gnt_vld & ~sel_we;
            s1_id_q  <= gnt_id;
            // Stage 2 marks the cycle in which the captured data is presented.
            s2_vld_q <= s1_vld_q;
            s2_id_q  <= s1_id_q;
            if (s1_vld_q) begin
                if (s1_id_q) begin
                    rdata1_q <= sram_dout;
                end else begin
                    rdata0_q <= sram_dout;
                end
            end
        end
    end

    assign m0_rvalid = s2_vld_q & ~s2_id_q;
    assign m1_rvalid = s2_vld_q & s2_id_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: drives sram_port_arbiter with directed and randomized
// traffic, against a behavioural model of the SRAM macro.
//
// A reference model holds the memory contents and a round-robin pointer with a
// streak count. It predicts every grant and command, and it queues the expected
// read responses. A separate monitor pops that queue and checks each rvalid
// pulse for its cycle, its requester and its data.
module tb_sram_port_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;
    localparam int unsigned MB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [MW-1:0] m0_wmask;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [MW-1:0] m1_wmask;
    logic          sram_csb, sram_web;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_WD   (AW),
        .DATA_WD   (DW),
        .MAX_BURST (MB)
    ) dut (
        .wb_clk_i   (clk),
        .rst_n      (rst_n),
        .m0_req     (m0_req),
        .m0_we      (m0_we),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_wmask   (m0_wmask),
        .m0_gnt     (m0_gnt),
        .m0_rvalid  (m0_rvalid),
        .m0_rdata   (m0_rdata),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_wmask   (m1_wmask),
        .m1_gnt     (m1_gnt),
        .m1_rvalid  (m1_rvalid),
        .m1_rdata   (m1_rdata),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } txn_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            cyc;
    } rsp_t;

    txn_t          q0[$];
    txn_t          q1[$];
    rsp_t          sb[$];
    int            win_log[$];
    logic [DW-1:0] sram_mem [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] last_rd [2];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            last_id = 1;
    int            streak = 0;
    bit            drop_en = 1'b0;

    // Behavioural macro: captures at the clock edge, and read data appears in
    // the following cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < int'(MW); b++) begin
                    if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                end
            end else begin
                sram_dout <= sram_mem[sram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(bit we, logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m);
        txn_t t;
        t.we   = we;
        t.addr = a;
        t.data = d;
        t.mask = m;
        return t;
    endfunction

    // Round-robin rule: the current holder keeps the port only while its
    // streak has started and is still below the burst limit.
    function automatic int ref_winner(bit r0, bit r1);
        if (r0 && r1) return (streak > 0 && streak < int'(MB)) ? last_id : 1 - last_id;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_csb"}, sram_csb, 1'b1);
        chk({tag, "_web"}, sram_web, 1'b1);
        chk({tag, "_wmask"}, sram_wmask, 0);
        chk({tag, "_addr"}, sram_addr, 0);
        chk({tag, "_din"}, sram_din, 0);
    endtask

    // One cycle: present the queue heads, then check the grant and the command
    // pins against the model, and advance the model.
    task automatic step();
        int   w;
        txn_t t;
        @(negedge clk);
        m0_req = (q0.size() > 0) && (!drop_en || $urandom_range(0, 3) != 0);
        m1_req = (q1.size() > 0) && (!drop_en || $urandom_range(0, 3) != 0);
        if (m0_req) begin
            m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].data; m0_wmask = q0[0].mask;
        end else begin
            m0_we = 1'($urandom); m0_addr = AW'($urandom); m0_wdata = $urandom;
            m0_wmask = MW'($urandom);
        end
        if (m1_req) begin
            m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].data; m1_wmask = q1[0].mask;
        end else begin
            m1_we = 1'($urandom); m1_addr = AW'($urandom); m1_wdata = $urandom;
            m1_wmask = MW'($urandom);
        end
        #1;
        w = ref_winner(m0_req, m1_req);
        chk("m0_gnt", m0_gnt, w == 0);
        chk("m1_gnt", m1_gnt, w == 1);
        if (w < 0) begin
            chk_idle_pins("idle");
        end else begin
            t = (w == 0) ? q0.pop_front() : q1.pop_front();
            chk("cmd_csb", sram_csb, 1'b0);
            chk("cmd_web", sram_web, !t.we);
            chk("cmd_addr", sram_addr, t.addr);
            chk("cmd_din", sram_din, t.data);
            chk("cmd_wmask", sram_wmask, t.we ? t.mask : 4'h0);
            if (t.we) begin
                for (int b = 0; b < int'(MW); b++) begin
                    if (t.mask[b]) ref_mem[t.addr][8*b +: 8] = t.data[8*b +: 8];
                end
            end else begin
                sb.push_back('{w, ref_mem[t.addr], cyc + 2});
            end
            if (w == last_id) begin
                streak = (streak < 15) ? streak + 1 : 15;
            end else begin
                last_id = w;
                streak  = 1;
            end
            win_log.push_back(w);
        end
    endtask

    // Assert reset at a falling edge, hold it with both requests high, and
    // check that the outputs stay at their reset values.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        q0.delete();
        q1.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        last_id = 1;
        streak  = 0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h33; m0_wdata = $urandom; m0_wmask = 4'hF;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h44; m1_wdata = $urandom; m1_wmask = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_m0_gnt", m0_gnt, 1'b0);
            chk("rst_m1_gnt", m1_gnt, 1'b0);
            chk("rst_m0_rdata", m0_rdata, 0);
            chk("rst_m1_rdata", m1_rdata, 0);
            chk_idle_pins("rst");
            @(negedge clk);
        end
        rst_n  = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    // Monitor: each cycle, either the queue head is due, or both rvalid must be
    // low. Between pulses, rdata must hold the last value delivered.
    initial begin
        rsp_t r;
        last_rd[0] = '0;
        last_rd[1] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                r = sb.pop_front();
                chk("rsp_m0_rvalid", m0_rvalid, r.id == 0);
                chk("rsp_m1_rvalid", m1_rvalid, r.id == 1);
                last_rd[r.id] = r.data;
            end else begin
                chk("quiet_m0_rvalid", m0_rvalid, 1'b0);
                chk("quiet_m1_rvalid", m1_rvalid, 1'b0);
            end
            chk("m0_rdata", m0_rdata, last_rd[0]);
            chk("m1_rdata", m1_rdata, last_rd[1]);
        end
    end

    initial begin
        int n;
        for (int a = 0; a < 256; a++) begin
            ref_mem[a]  = $urandom;
            sram_mem[a] <= ref_mem[a];
        end
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
        do_reset();

        // Read after write on requester 0.
        q0.push_back(mk(1'b1, 8'h05, 32'hDEADBEEF, 4'hF));
        q0.push_back(mk(1'b0, 8'h05, '0, 4'h0));
        repeat (5) step();

        // Byte-masked merge.
        q0.push_back(mk(1'b1, 8'h10, 32'h11223344, 4'hF));
        q0.push_back(mk(1'b1, 8'h10, 32'hAABBCCDD, 4'h5));
        q0.push_back(mk(1'b0, 8'h10, '0, 4'h0));
        repeat (6) step();

        // Pipelined reads that alternate requesters in consecutive cycles.
        q0.push_back(mk(1'b1, 8'h00, 32'hA0, 4'hF));
        q0.push_back(mk(1'b1, 8'h01, 32'hA1, 4'hF));
        q0.push_back(mk(1'b1, 8'h02, 32'hA2, 4'hF));
        repeat (3) step();
        q0.push_back(mk(1'b0, 8'h00, '0, 4'h0));
        step();
        q1.push_back(mk(1'b0, 8'h01, '0, 4'h0));
        step();
        q0.push_back(mk(1'b0, 8'h02, '0, 4'h0));
        step();
        repeat (4) step();

        // Fairness from reset with both requesters busy.
        do_reset();
        win_log.delete();
        for (int i = 0; i < 12; i++) begin
            q0.push_back(mk(1'b0, AW'($urandom), '0, 4'h0));
            q1.push_back(mk(1'b0, AW'($urandom), '0, 4'h0));
        end
        repeat (12) step();
        for (int i = 0; i < 12; i++) chk("fair_seq", win_log[i], (i / 4) % 2);
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 40) begin
            step();
            n++;
        end
        repeat (3) step();

        // Reset one cycle after a requester-1 read grant. The read must not return.
        q1.push_back(mk(1'b0, 8'h05, '0, 4'h0));
        step();
        do_reset();
        win_log.delete();
        q0.push_back(mk(1'b0, 8'h10, '0, 4'h0));
        q1.push_back(mk(1'b0, 8'h02, '0, 4'h0));
        step();
        chk("post_rst_first", win_log[0], 0);
        repeat (4) step();

        // Requester 1 alone for ten cycles, then contention after its long streak.
        win_log.delete();
        for (int i = 0; i < 10; i++) q1.push_back(mk(1'b0, AW'(i), '0, 4'h0));
        repeat (10) step();
        n = 0;
        foreach (win_log[i]) if (win_log[i] == 1) n++;
        chk("solo_m1_grants", n, 10);
        q0.push_back(mk(1'b1, 8'h20, $urandom, 4'hF));
        q1.push_back(mk(1'b1, 8'h21, $urandom, 4'hF));
        repeat (5) step();

        // Randomized traffic, with requests that are sometimes withdrawn.
        drop_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (q0.size() < 2 && $urandom_range(0, 1) == 1)
                q0.push_back(mk(1'($urandom), AW'($urandom_range(0, 15)), $urandom, MW'($urandom)));
            if (q1.size() < 2 && $urandom_range(0, 1) == 1)
                q1.push_back(mk(1'($urandom), AW'($urandom_range(0, 15)), $urandom, MW'($urandom)));
            step();
        end
        drop_en = 1'b0;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 40) begin
            step();
            n++;
        end
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
